t03_pixel_compositor: RTL and testbench
=======================================

# t03_pixel_compositor

Parametrised, pipelined pixel compositor for the team 03 display path. It merges NUM_LAYERS sprite layers, a text layer and a region-based background into one color per pixel. It applies per-layer blinking driven by a frame counter and reports per-layer sprite overlap (collision) once per frame. It sits between the sprite/text generators and the VGA output stage, driven by the same Hcnt/Vcnt timing counters.

## Interface

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has the highest priority.
- COLOR_W, 8, color width in bits (RRRGGGBB when 8).
- CNT_W, 11, width of Hcnt/Vcnt.
- X_MIN, 37 / X_MAX, 600, horizontal playfield bounds; both exclusive.
- Y_MIN, 29 / Y_SPLIT, 600 / Y_MAX, 800, vertical region bounds.
- BG_PLAY, 8'b01010111, playfield background color.
- BG_FLOOR, 8'b00010100, floor-band background color.
- BLINK_FRAMES, 30, frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  the current Hcnt/Vcnt/layer inputs are a visible pixel.
- Hcnt  in  CNT_W  horizontal pixel counter.
- Vcnt  in  CNT_W  vertical line counter.
- frame_start  in  1  single-cycle pulse at the start of each frame.
- layer_pix  in  NUM_LAYERS*COLOR_W  layer colors; layer i is at [i*COLOR_W +: COLOR_W]; 0 means transparent.
- layer_blink  in  NUM_LAYERS  per-layer blink enable.
- text_sprite  in  COLOR_W  text glyph mask; non-zero means the text pixel is on.
- text_color  in  COLOR_W  color used for text pixels.
- color_out  out  COLOR_W  composited color, registered.
- pix_valid_out  out  1  pix_valid delayed to align with color_out.
- collision  out  NUM_LAYERS  per-layer overlap flags for the previous frame.
- blink_phase  out  1  current blink phase; 1 means blinking layers are hidden.

## Operation

- Effective opacity: layer i is opaque when its layer_pix slice is non-zero AND NOT (blink_phase AND layer_blink[i]).
- Color select, evaluated in priority order:
  - the lowest-index opaque layer;
  - otherwise text_color, if text_sprite is non-zero;
  - otherwise the background color.
- Background color:
  - 0 unless X_MIN < Hcnt < X_MAX;
  - inside that horizontal range: BG_PLAY when Y_MIN < Vcnt < Y_SPLIT, BG_FLOOR when Y_SPLIT ≤ Vcnt < Y_MAX, 0 otherwise.
- When pix_valid is 0, the selected color is forced to 0 and the collision accumulator is not updated.
- Collision accumulator (NUM_LAYERS bits):
  - on each valid pixel where two or more layers are opaque, every opaque layer's bit is OR-set;
  - blink-hidden layers do not count.
- At frame_start:
  - collision ← accumulator, including that cycle's own contribution if it is a valid pixel;
  - the accumulator then clears;
  - collision holds its value until the next frame_start.
- Blink counter (width clog2(BLINK_FRAMES), minimum 1 bit):
  - increments on frame_start;
  - on frame_start with count = BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles;
  - with BLINK_FRAMES = 1, blink_phase toggles on every frame_start.
- The blink_phase change takes effect for pixels presented in the cycle after the frame_start pulse.
- Arithmetic: all region compares are unsigned at CNT_W. Constants are zero-extended or truncated to the port widths.

## Timing

- Two-stage pipeline.
  - Stage 1 registers the effective opacity vector, the priority-selected layer color, the text decision and the background color.
  - Stage 2 registers color_out.
- Latency from inputs to color_out and pix_valid_out is exactly 2 cycles. Throughput is one pixel per cycle with no stalls.
- The collision accumulator and blink counter update on the clk edge using the stage-0 (input) signals. The collision output changes 1 cycle after frame_start is sampled.
- Reset values (nrst low, asynchronous):
  - color_out = 0, pix_valid_out = 0, collision = 0, blink_phase = 0;
  - blink counter, accumulator and all pipeline registers = 0.
- Reset mid-frame: outputs drop to 0 immediately. The first valid output appears 2 cycles after the first valid pixel following the nrst release.
- Simultaneous events: frame_start together with a valid colliding pixel is included in the latched collision value.

## Test plan

- Priority: layer0 = 0x00, layer1 = 0xE0, layer2 = 0x1C, text_sprite = 0x01, text_color = 0xFF, pix_valid = 1 -> color_out = 0xE0 two cycles later, pix_valid_out = 1.
- Background regions: all layers and text 0. (Hcnt, Vcnt) = (100, 100) -> 0x57; (100, 700) -> 0x14; (37, 100) -> 0x00; (100, 800) -> 0x00; pix_valid = 0 -> 0x00.
- Collision: one frame with a pixel where layer0 = 0x03 and layer2 = 0x10 overlap, then frame_start -> collision = 4'b0101 one cycle later. The next frame has no overlap -> collision = 0 after the following frame_start.
- Blink: BLINK_FRAMES = 2, layer_blink = 4'b0001, layer0 = 0xE0 held. After 2 frame_start pulses -> blink_phase = 1 and color_out shows layer1 or background. After 2 more pulses -> blink_phase = 0 and 0xE0 returns. A hidden layer0 overlapping layer1 sets no collision bit.
- Frame_start coincident with collision: an overlap pixel exactly on the frame_start cycle -> that bit is set in the latched collision, and the accumulator is cleared for the new frame.
- Async reset mid-frame: assert nrst low between clock edges during streaming -> all outputs are 0 immediately. After release, feed a pixel at (100, 100) -> 0x57 exactly 2 cycles later, and blink_phase = 0.

Source files
------------

// File: rtl/t03_pixel_compositor.sv
// t03_pixel_compositor
// Merges NUM_LAYERS sprite layers, a text layer and a region-based background
// into one color per pixel through a two-stage pipeline. It also hides
// blink-enabled layers on alternate blink half-periods and reports per-layer
// sprite overlap once per frame.
//
// Ports:
//   clk, nrst          system clock, asynchronous active-low reset
//   pix_valid          current Hcnt/Vcnt/layer inputs are a visible pixel
//   Hcnt, Vcnt         timing counters (CNT_W bits)
//   frame_start        one-cycle pulse at the start of each frame
//   layer_pix          packed layer colors; layer i at [i*COLOR_W +: COLOR_W], 0 = transparent
//   layer_blink        per-layer blink enable
//   text_sprite        text glyph mask; non-zero = text pixel on
//   text_color         color used for text pixels
//   color_out          composited color, 2 cycles after the inputs
//   pix_valid_out      pix_valid aligned with color_out
//   collision          per-layer overlap flags latched at the last frame_start
//   blink_phase        1 = blink-enabled layers are hidden
module t03_pixel_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter int          COLOR_W      = 8,
  parameter int          CNT_W        = 11,
  parameter int          X_MIN        = 37,
  parameter int          X_MAX        = 600,
  parameter int          Y_MIN        = 29,
  parameter int          Y_SPLIT      = 600,
  parameter int          Y_MAX        = 800,
  parameter int unsigned BG_PLAY      = 8'b01010111,
  parameter int unsigned BG_FLOOR     = 8'b00010100,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          pix_valid,
  input  logic [CNT_W-1:0]              Hcnt,
  input  logic [CNT_W-1:0]              Vcnt,
  input  logic                          frame_start,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pix,
  input  logic [NUM_LAYERS-1:0]         layer_blink,
  input  logic [COLOR_W-1:0]            text_sprite,
  input  logic [COLOR_W-1:0]            text_color,
  output logic [COLOR_W-1:0]            color_out,
  output logic                          pix_valid_out,
  output logic [NUM_LAYERS-1:0]         collision,
  output logic                          blink_phase
);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [CNT_W-1:0] X_MIN_C   = CNT_W'(X_MIN);
  localparam logic [CNT_W-1:0] X_MAX_C   = CNT_W'(X_MAX);
  localparam logic [CNT_W-1:0] Y_MIN_C   = CNT_W'(Y_MIN);
  localparam logic [CNT_W-1:0] Y_SPLIT_C = CNT_W'(Y_SPLIT);
  localparam logic [CNT_W-1:0] Y_MAX_C   = CNT_W'(Y_MAX);
  localparam logic [COLOR_W-1:0] BG_PLAY_C  = COLOR_W'(BG_PLAY);
  localparam logic [COLOR_W-1:0] BG_FLOOR_C = COLOR_W'(BG_FLOOR);

  // stage 0 (combinational on the inputs)
  logic [NUM_LAYERS-1:0] opaque;
  logic [COLOR_W-1:0]    layer_sel;
  logic [COLOR_W-1:0]    bg_color;
  logic                  in_x;
  logic                  multi_hit;
  logic [NUM_LAYERS-1:0] hit;

  // Walk from the lowest priority upward so the lowest-index opaque layer
  // is the last one to overwrite layer_sel.
  always_comb begin
    opaque    = '0;
    layer_sel = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque[i] = (|layer_pix[i*COLOR_W +: COLOR_W]) && !(blink_phase && layer_blink[i]);
      if (opaque[i]) layer_sel = layer_pix[i*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    bg_color = '0;
    in_x     = (Hcnt > X_MIN_C) && (Hcnt < X_MAX_C);
    if (in_x) begin
      if ((Vcnt > Y_MIN_C) && (Vcnt < Y_SPLIT_C))      bg_color = BG_PLAY_C;
      else if ((Vcnt >= Y_SPLIT_C) && (Vcnt < Y_MAX_C)) bg_color = BG_FLOOR_C;
    end
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_hit = |(opaque & (opaque - NUM_LAYERS'(1)));
  assign hit       = (pix_valid && multi_hit) ? opaque : '0;

  // stage 1 registers
  logic                  s1_valid;
  logic [NUM_LAYERS-1:0] s1_opaque;
  logic [COLOR_W-1:0]    s1_layer;
  logic                  s1_text_on;
  logic [COLOR_W-1:0]    s1_text_color;
  logic [COLOR_W-1:0]    s1_bg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid      <= 1'b0;
      s1_opaque     <= '0;
      s1_layer      <= '0;
      s1_text_on    <= 1'b0;
      s1_text_color <= '0;
      s1_bg         <= '0;
    end else begin
      s1_valid      <= pix_valid;
      s1_opaque     <= opaque;
      s1_layer      <= layer_sel;
      s1_text_on    <= |text_sprite;
      s1_text_color <= text_color;
      s1_bg         <= bg_color;
    end
  end

  // stage 2: final select, blanked for non-visible pixels
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      color_out     <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      pix_valid_out <= s1_valid;
      if (!s1_valid)       color_out <= '0;
      else if (|s1_opaque) color_out <= s1_layer;
      else if (s1_text_on) color_out <= s1_text_color;
      else                 color_out <= s1_bg;
    end
  end

  // Collision accumulator; a hit on the frame_start cycle lands in the
  // latched value, not in the new frame.
  logic [NUM_LAYERS-1:0] coll_acc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      coll_acc  <= '0;
      collision <= '0;
    end else if (frame_start) begin
      collision <= coll_acc | hit;
      coll_acc  <= '0;
    end else begin
      coll_acc  <= coll_acc | hit;
    end
  end

  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_t03_pixel_compositor.sv
module tb_t03_pixel_compositor;

  logic        clk;
  logic        nrst;
  logic        pix_valid;
  logic [10:0] Hcnt;
  logic [10:0] Vcnt;
  logic        frame_start;
  logic [31:0] layer_pix;
  logic [3:0]  layer_blink;
  logic [7:0]  text_sprite;
  logic [7:0]  text_color;
  logic [7:0]  color_out;
  logic        pix_valid_out;
  logic [3:0]  collision;
  logic        blink_phase;

  t03_pixel_compositor #(.BLINK_FRAMES(2)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .pix_valid    (pix_valid),
    .Hcnt         (Hcnt),
    .Vcnt         (Vcnt),
    .frame_start  (frame_start),
    .layer_pix    (layer_pix),
    .layer_blink  (layer_blink),
    .text_sprite  (text_sprite),
    .text_color   (text_color),
    .color_out    (color_out),
    .pix_valid_out(pix_valid_out),
    .collision    (collision),
    .blink_phase  (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int         due;
    logic       v;
    logic [7:0] c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  logic       m_phase = 1'b0;
  int         m_cnt   = 0;
  logic [3:0] m_acc   = '0;
  logic [3:0] m_coll  = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bg_of(input logic [10:0] h, input logic [10:0] v);
    if (!(h > 11'd37 && h < 11'd600)) return 8'h00;
    if (v > 11'd29 && v < 11'd600)    return 8'h57;
    if (v >= 11'd600 && v < 11'd800)  return 8'h14;
    return 8'h00;
  endfunction

  task automatic drive(input logic v, input logic [10:0] h, input logic [10:0] vc,
                       input logic fs, input logic [31:0] lp, input logic [3:0] lb,
                       input logic [7:0] ts, input logic [7:0] tc);
    logic [3:0] opq;
    logic [7:0] e;
    logic       found;
    int         nop;
    exp_t       it;
    @(negedge clk);
    pix_valid = v; Hcnt = h; Vcnt = vc; frame_start = fs;
    layer_pix = lp; layer_blink = lb; text_sprite = ts; text_color = tc;
    nop = 0; found = 1'b0; e = 8'h00;
    for (int i = 0; i < 4; i++) begin
      opq[i] = (lp[i*8 +: 8] != 8'h00) && !(m_phase && lb[i]);
      if (opq[i]) nop++;
    end
    for (int i = 0; i < 4; i++)
      if (!found && opq[i]) begin e = lp[i*8 +: 8]; found = 1'b1; end
    if (!found) e = (ts != 8'h00) ? tc : bg_of(h, vc);
    if (!v) e = 8'h00;
    it.due = cyc + 2; it.v = v; it.c = e;
    q.push_back(it);
    if (v && nop >= 2) m_acc = m_acc | opq;
    if (fs) begin
      m_coll = m_acc;
      m_acc  = '0;
      if (m_cnt == 1) begin m_cnt = 0; m_phase = ~m_phase; end
      else m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 11'd0, 11'd0, 1'b0, 32'h0, 4'h0, 8'h0, 8'h0);
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic fs,
                     input logic [31:0] lp, input logic [3:0] lb);
    drive(1'b1, h, v, fs, lp, lb, 8'h00, 8'h00);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t it;
        it = q.pop_front();
        check_val("pix_valid_out", {31'b0, pix_valid_out}, {31'b0, it.v});
        check_val("color_out", {24'b0, color_out}, {24'b0, it.c});
      end
      check_val("collision_trk", {28'b0, collision}, {28'b0, m_coll});
      check_val("blink_trk", {31'b0, blink_phase}, {31'b0, m_phase});
    end
  end

  initial begin
    nrst = 1'b0; pix_valid = 1'b0; Hcnt = '0; Vcnt = '0; frame_start = 1'b0;
    layer_pix = '0; layer_blink = '0; text_sprite = '0; text_color = '0;
    #12;
    check_val("rst_color", {24'b0, color_out}, 32'h0);
    check_val("rst_valid", {31'b0, pix_valid_out}, 32'h0);
    check_val("rst_coll", {28'b0, collision}, 32'h0);
    check_val("rst_blink", {31'b0, blink_phase}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    idle(2);

    // priority: layer1 beats layer2, text and background
    drive(1'b1, 11'd100, 11'd100, 1'b0, {8'h00, 8'h1C, 8'hE0, 8'h00}, 4'h0, 8'h01, 8'hFF);
    // text over background, then layer0 over text
    drive(1'b1, 11'd100, 11'd100, 1'b0, 32'h0, 4'h0, 8'h01, 8'hFF);
    drive(1'b1, 11'd100, 11'd100, 1'b0, {8'h00, 8'h00, 8'h00, 8'h42}, 4'h0, 8'h01, 8'hFF);

    // background regions and bounds
    pix(11'd100, 11'd100, 1'b0, 32'h0, 4'h0);
    pix(11'd100, 11'd700, 1'b0, 32'h0, 4'h0);
    pix(11'd37,  11'd100, 1'b0, 32'h0, 4'h0);
    pix(11'd100, 11'd800, 1'b0, 32'h0, 4'h0);
    pix(11'd38,  11'd30,  1'b0, 32'h0, 4'h0);
    pix(11'd599, 11'd599, 1'b0, 32'h0, 4'h0);
    pix(11'd600, 11'd100, 1'b0, 32'h0, 4'h0);
    pix(11'd100, 11'd29,  1'b0, 32'h0, 4'h0);
    pix(11'd100, 11'd600, 1'b0, 32'h0, 4'h0);
    pix(11'd100, 11'd799, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 11'd100, 11'd100, 1'b0, {8'h00, 8'h00, 8'hE0, 8'h00}, 4'h0, 8'h01, 8'hFF);
    idle(2);

    // blink with BLINK_FRAMES = 2 on layer0
    pix(11'd100, 11'd100, 1'b0, 32'h0000_00E0, 4'h1);
    pix(11'd100, 11'd100, 1'b1, 32'h0000_00E0, 4'h1);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_00E0, 4'h1);
    pix(11'd100, 11'd100, 1'b1, 32'h0000_00E0, 4'h1);
    after_edge();
    check_val("blink_on", {31'b0, blink_phase}, 32'h1);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_00E0, 4'h1);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_1CE0, 4'h1);
    pix(11'd100, 11'd100, 1'b1, 32'h0000_1CE0, 4'h1);
    after_edge();
    check_val("blink_hidden_nocoll", {28'b0, collision}, 32'h0);
    pix(11'd100, 11'd100, 1'b1, 32'h0000_00E0, 4'h1);
    after_edge();
    check_val("blink_off", {31'b0, blink_phase}, 32'h0);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_00E0, 4'h1);
    idle(2);

    // collision within a frame
    pix(11'd100, 11'd100, 1'b0, 32'h0010_0003, 4'h0);
    pix(11'd101, 11'd100, 1'b0, 32'h0000_0003, 4'h0);
    drive(1'b0, 11'd0, 11'd0, 1'b1, 32'h0, 4'h0, 8'h0, 8'h0);
    after_edge();
    check_val("coll_0101", {28'b0, collision}, 32'h5);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_0003, 4'h0);
    drive(1'b0, 11'd0, 11'd0, 1'b0, 32'h0010_0003, 4'h0, 8'h0, 8'h0);
    idle(3);
    check_val("coll_hold", {28'b0, collision}, 32'h5);
    drive(1'b0, 11'd0, 11'd0, 1'b1, 32'h0, 4'h0, 8'h0, 8'h0);
    after_edge();
    check_val("coll_clear", {28'b0, collision}, 32'h0);

    // overlap exactly on the frame_start cycle
    pix(11'd100, 11'd100, 1'b1, 32'h4000_2000, 4'h0);
    after_edge();
    check_val("coll_coincident", {28'b0, collision}, 32'hA);
    drive(1'b0, 11'd0, 11'd0, 1'b1, 32'h0, 4'h0, 8'h0, 8'h0);
    after_edge();
    check_val("coll_acc_cleared", {28'b0, collision}, 32'h0);

    // move blink_phase to 1, then reset mid-stream
    pix(11'd100, 11'd100, 1'b1, 32'h0, 4'h0);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_0300, 4'h0);
    pix(11'd100, 11'd100, 1'b0, 32'h0001_0003, 4'h0);
    pix(11'd100, 11'd100, 1'b1, 32'h0, 4'h0);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_00E0, 4'h0);
    pix(11'd100, 11'd100, 1'b0, 32'h0000_00E0, 4'h0);
    @(posedge clk);
    #3;
    nrst = 1'b0;
    q.delete();
    m_phase = 1'b0; m_cnt = 0; m_acc = '0; m_coll = '0;
    #1;
    check_val("arst_color", {24'b0, color_out}, 32'h0);
    check_val("arst_valid", {31'b0, pix_valid_out}, 32'h0);
    check_val("arst_coll", {28'b0, collision}, 32'h0);
    check_val("arst_blink", {31'b0, blink_phase}, 32'h0);
    idle(2);
    nrst = 1'b1;
    pix(11'd100, 11'd100, 1'b0, 32'h0, 4'h0);
    after_edge();
    check_val("post_rst_blink", {31'b0, blink_phase}, 32'h0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
